// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared constants and types for the writeback arbiter.
//   - Default widths for result/PC, instruction type and ROB tag.
//   - Requester count and fixed requester indices (ALU, MEM, MUL).
//   - rr_next(): round-robin successor of a requester index.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

   localparam int WB_WORD_SIZE       = 32;
   localparam int WB_INSTR_TYPE_SZ   = 4;
   localparam int WB_ROB_ENTRY_WIDTH = 5;

   localparam int NUM_WB_REQ = 3;
   localparam int WB_SRC_W   = 2;

   typedef logic [WB_SRC_W-1:0] wb_src_t;

   typedef enum logic [WB_SRC_W-1:0] {
      REQ_ALU = 2'd0,
      REQ_MEM = 2'd1,
      REQ_MUL = 2'd2
   } wb_req_e;

   // Next index after idx, wrapping at NUM_WB_REQ.
   function automatic wb_src_t rr_next(input wb_src_t idx);
      return (int'(idx) == NUM_WB_REQ - 1) ? '0 : wb_src_t'(idx + wb_src_t'(1));
   endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The scan starts at ptr_i and
// proceeds upward, wrapping modulo N; the first set candidate wins.
// Ports:
//   cand_i   in  N   candidate vector
//   ptr_i    in  2   scan start index (0..N-1)
//   grant_o  out N   one-hot grant (all zero when no candidate)
//   winner_o out 2   encoded winner (0 when no candidate)
//   any_o    out 1   a grant was made
// -----------------------------------------------------------------------------
module rr_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int N = NUM_WB_REQ
) (
   input  logic [N-1:0] cand_i,
   input  wb_src_t      ptr_i,
   output logic [N-1:0] grant_o,
   output wb_src_t      winner_o,
   output logic         any_o
);

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, so no path leaves a value held (no latch).
   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      any_o    = 1'b0;
      for (int k = 0; k < N; k++) begin
         automatic int idx = (int'(ptr_i) + k) % N;
         if (!any_o && cand_i[idx]) begin
            grant_o[idx] = 1'b1;
            winner_o     = wb_src_t'(idx);
            any_o        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter sharing the single ROB completion port among the ALU,
// memory and multiplier pipelines. Each requester owns a one-entry holding
// buffer with ready/valid backpressure; a round-robin scheduler moves one
// result per cycle into the registered writeback output.
//
// Optional feature: define WB_ARB_BYPASS_EN to let a requester with an empty
// buffer compete with its live input, cutting latency from 2 to 1 cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   flush        in   synchronous flush; drops buffered and in-flight results
//   req_valid    in   per-requester result valid
//   req_ready    out  per-requester accept
//   req_type/pc/result/rob_id  in  flattened payload, requester i at slice i
//   wb_valid     out  registered writeback valid
//   wb_type/pc/result/rob_id   out registered writeback payload
//   wb_src       out  index of the granted requester
// -----------------------------------------------------------------------------
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int WORD_SIZE       = WB_WORD_SIZE,
   parameter int INSTR_TYPE_SZ   = WB_INSTR_TYPE_SZ,
   parameter int ROB_ENTRY_WIDTH = WB_ROB_ENTRY_WIDTH,
   parameter int NUM_REQ         = NUM_WB_REQ
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*INSTR_TYPE_SZ-1:0]   req_type,
   input  logic [NUM_REQ*WORD_SIZE-1:0]       req_pc,
   input  logic [NUM_REQ*WORD_SIZE-1:0]       req_result,
   input  logic [NUM_REQ*ROB_ENTRY_WIDTH-1:0] req_rob_id,
   output logic                               wb_valid,
   output logic [INSTR_TYPE_SZ-1:0]           wb_type,
   output logic [WORD_SIZE-1:0]               wb_pc,
   output logic [WORD_SIZE-1:0]               wb_result,
   output logic [ROB_ENTRY_WIDTH-1:0]         wb_rob_id,
   output wb_src_t                            wb_src
);

`ifdef WB_ARB_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   // Holding buffers
   logic [NUM_REQ-1:0]         buf_valid_q, buf_valid_d;
   logic [INSTR_TYPE_SZ-1:0]   buf_type_q   [NUM_REQ];
   logic [WORD_SIZE-1:0]       buf_pc_q     [NUM_REQ];
   logic [WORD_SIZE-1:0]       buf_result_q [NUM_REQ];
   logic [ROB_ENTRY_WIDTH-1:0] buf_rob_q    [NUM_REQ];

   // Unpacked view of the live inputs
   logic [INSTR_TYPE_SZ-1:0]   live_type   [NUM_REQ];
   logic [WORD_SIZE-1:0]       live_pc     [NUM_REQ];
   logic [WORD_SIZE-1:0]       live_result [NUM_REQ];
   logic [ROB_ENTRY_WIDTH-1:0] live_rob    [NUM_REQ];

   // Arbitration
   logic [NUM_REQ-1:0] cand, grant, accept, load;
   wb_src_t            winner;
   logic               any_grant, do_grant;
   wb_src_t            rr_ptr_q, rr_ptr_d;

   // Writeback register
   logic                       wb_valid_q, wb_valid_d;
   logic [INSTR_TYPE_SZ-1:0]   wb_type_q, wb_type_d;
   logic [WORD_SIZE-1:0]       wb_pc_q, wb_pc_d;
   logic [WORD_SIZE-1:0]       wb_result_q, wb_result_d;
   logic [ROB_ENTRY_WIDTH-1:0] wb_rob_q, wb_rob_d;
   wb_src_t                    wb_src_q, wb_src_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         live_type[i]   = req_type[i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
         live_pc[i]     = req_pc[i*WORD_SIZE +: WORD_SIZE];
         live_result[i] = req_result[i*WORD_SIZE +: WORD_SIZE];
         live_rob[i]    = req_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
      end
   end

   // With bypass, an empty buffer lets its live input compete directly.
   always_comb begin
      cand = buf_valid_q;
      if (BYPASS_EN) cand = buf_valid_q | req_valid;
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .cand_i   (cand),
      .ptr_i    (rr_ptr_q),
      .grant_o  (grant),
      .winner_o (winner),
      .any_o    (any_grant)
   );

   // A granted buffer drains this cycle, so it can take a new result at once.
   assign req_ready = {NUM_REQ{!flush}} & (~buf_valid_q | grant);
   assign accept    = req_valid & req_ready;
   assign do_grant  = any_grant && !flush;

   // A live input that won arbitration goes straight to the output and is
   // not also written into its buffer.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         load[i] = accept[i] && !(BYPASS_EN && grant[i] && !buf_valid_q[i]);
      end
      buf_valid_d = flush ? '0 : ((buf_valid_q & ~grant) | load);
   end

   always_comb begin
      wb_valid_d  = do_grant;
      wb_type_d   = wb_type_q;
      wb_pc_d     = wb_pc_q;
      wb_result_d = wb_result_q;
      wb_rob_d    = wb_rob_q;
      wb_src_d    = wb_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (do_grant) begin
         wb_src_d = winner;
         rr_ptr_d = rr_next(winner);
         if (buf_valid_q[winner]) begin
            wb_type_d   = buf_type_q[winner];
            wb_pc_d     = buf_pc_q[winner];
            wb_result_d = buf_result_q[winner];
            wb_rob_d    = buf_rob_q[winner];
         end else begin
            wb_type_d   = live_type[winner];
            wb_pc_d     = live_pc[winner];
            wb_result_d = live_result[winner];
            wb_rob_d    = live_rob[winner];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_valid_q <= '0;
         rr_ptr_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_type_q   <= '0;
         wb_pc_q     <= '0;
         wb_result_q <= '0;
         wb_rob_q    <= '0;
         wb_src_q    <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         rr_ptr_q    <= rr_ptr_d;
         wb_valid_q  <= wb_valid_d;
         wb_type_q   <= wb_type_d;
         wb_pc_q     <= wb_pc_d;
         wb_result_q <= wb_result_d;
         wb_rob_q    <= wb_rob_d;
         wb_src_q    <= wb_src_d;
      end
   end

   // NOTE: buffer payload storage is deliberately not reset; buf_valid_q
   // qualifies it, so stale contents are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (load[i]) begin
            buf_type_q[i]   <= live_type[i];
            buf_pc_q[i]     <= live_pc[i];
            buf_result_q[i] <= live_result[i];
            buf_rob_q[i]    <= live_rob[i];
         end
      end
   end

   assign wb_valid  = wb_valid_q;
   assign wb_type   = wb_type_q;
   assign wb_pc     = wb_pc_q;
   assign wb_result = wb_result_q;
   assign wb_rob_id = wb_rob_q;
   assign wb_src    = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int WS = WB_WORD_SIZE;
   localparam int IT = WB_INSTR_TYPE_SZ;
   localparam int RW = WB_ROB_ENTRY_WIDTH;
   localparam int N  = NUM_WB_REQ;

`ifdef WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
   localparam int LAT = 1;
`else
   localparam bit BYP = 1'b0;
   localparam int LAT = 2;
`endif

   logic            clk   = 1'b0;
   logic            reset = 1'b1;
   logic            flush;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*IT-1:0] req_type;
   logic [N*WS-1:0] req_pc, req_result;
   logic [N*RW-1:0] req_rob_id;
   logic            wb_valid;
   logic [IT-1:0]   wb_type;
   logic [WS-1:0]   wb_pc, wb_result;
   logic [RW-1:0]   wb_rob_id;
   wb_src_t         wb_src;

   wb_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_type   (req_type),
      .req_pc     (req_pc),
      .req_result (req_result),
      .req_rob_id (req_rob_id),
      .wb_valid   (wb_valid),
      .wb_type    (wb_type),
      .wb_pc      (wb_pc),
      .wb_result  (wb_result),
      .wb_rob_id  (wb_rob_id),
      .wb_src     (wb_src)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   bit            m_bv   [N];
   logic [IT-1:0] m_type [N];
   logic [WS-1:0] m_pc   [N];
   logic [WS-1:0] m_res  [N];
   logic [RW-1:0] m_rob  [N];
   int            m_ptr;
   bit            m_wbv;
   logic [IT-1:0] m_wtype;
   logic [WS-1:0] m_wpc, m_wres;
   logic [RW-1:0] m_wrob;
   int            m_src;
   int            m_win;
   logic [N-1:0]  m_ready;
   logic [N-1:0]  m_acc;

   function automatic logic [IT-1:0] live_type(input int i);
      return req_type[i*IT +: IT];
   endfunction
   function automatic logic [WS-1:0] live_pc(input int i);
      return req_pc[i*WS +: WS];
   endfunction
   function automatic logic [WS-1:0] live_res(input int i);
      return req_result[i*WS +: WS];
   endfunction
   function automatic logic [RW-1:0] live_rob(input int i);
      return req_rob_id[i*RW +: RW];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
      m_ptr = 0; m_wbv = 1'b0; m_src = 0;
      m_wtype = '0; m_wpc = '0; m_wres = '0; m_wrob = '0;
      m_acc = '0;
   endtask

   // Who wins this cycle and who may hand over a result.
   task automatic model_eval();
      m_win = -1;
      for (int k = 0; k < N; k++) begin
         automatic int idx = (m_ptr + k) % N;
         if (m_win < 0 && (m_bv[idx] || (BYP && req_valid[idx]))) m_win = idx;
      end
      for (int i = 0; i < N; i++) m_ready[i] = !flush && (!m_bv[i] || m_win == i);
      m_acc = req_valid & m_ready;
   endtask

   task automatic model_commit();
      if (flush) begin
         for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
         m_wbv = 1'b0;
      end else begin
         if (m_win >= 0) begin
            if (m_bv[m_win]) begin
               m_wtype = m_type[m_win]; m_wpc = m_pc[m_win];
               m_wres  = m_res[m_win];  m_wrob = m_rob[m_win];
            end else begin
               m_wtype = live_type(m_win); m_wpc = live_pc(m_win);
               m_wres  = live_res(m_win);  m_wrob = live_rob(m_win);
            end
            m_src = m_win;
            m_ptr = (m_win + 1) % N;
            m_wbv = 1'b1;
         end else begin
            m_wbv = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            automatic bit went_direct = BYP && m_win == i && !m_bv[i];
            if (m_win == i) m_bv[i] = 1'b0;
            if (m_acc[i] && !went_direct) begin
               m_bv[i] = 1'b1;
               m_type[i] = live_type(i); m_pc[i] = live_pc(i);
               m_res[i]  = live_res(i);  m_rob[i] = live_rob(i);
            end
         end
      end
   endtask

   // One clock: inputs are already driven; ends 1 ns after the rising edge.
   task automatic cycle();
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic set_req(input int i, input logic [IT-1:0] t, input logic [WS-1:0] pc,
                          input logic [WS-1:0] res, input logic [RW-1:0] rob);
      req_type[i*IT +: IT]   = t;
      req_pc[i*WS +: WS]     = pc;
      req_result[i*WS +: WS] = res;
      req_rob_id[i*RW +: RW] = rob;
   endtask

   task automatic do_reset();
      reset = 1'b0; req_valid = '0; flush = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      flush = 1'b0; req_valid = '0;
      req_type = '0; req_pc = '0; req_result = '0; req_rob_id = '0;
      #1 reset = 1'b0;
      #1;
      n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
      n_tests++; if ({wb_type, wb_pc, wb_result, wb_rob_id} !== '0) begin n_fail++; $display("FAIL reset_payload: got %0h want 0", {wb_type, wb_pc, wb_result, wb_rob_id}); end
      n_tests++; if (wb_src !== 2'd0) begin n_fail++; $display("FAIL reset_wb_src: got %0d want 0", wb_src); end
      n_tests++; if (req_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", req_ready); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic test_single_alu();
      do_reset();
      set_req(REQ_ALU, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3);
      req_valid = 3'b001;
      cycle();
      req_valid = '0;
      for (int n = 1; n <= 3; n++) begin
         if (n > 1) cycle();
         n_tests++; if (wb_valid !== (n == LAT)) begin n_fail++; $display("FAIL single_valid_edge%0d: got %0b want %0b", n, wb_valid, n == LAT); end
         if (n == LAT) begin
            n_tests++; if (wb_result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_result: got %0h want deadbeef", wb_result); end
            n_tests++; if (wb_rob_id !== 5'd3) begin n_fail++; $display("FAIL single_rob: got %0d want 3", wb_rob_id); end
            n_tests++; if (wb_src !== 2'd0) begin n_fail++; $display("FAIL single_src: got %0d want 0", wb_src); end
         end
      end
   endtask

   task automatic test_all_three();
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 4'(i), 32'(i * 4), 32'h5000_0000 + 32'(i), 5'(10 + i));
      req_valid = 3'b111;
      #1;
      n_tests++; if (req_ready !== 3'b111) begin n_fail++; $display("FAIL all3_ready_accept: got %b want 111", req_ready); end
      cycle();
      req_valid = '0;
      for (int n = 1; n <= 4; n++) begin
         automatic bit exp_v = (n >= LAT) && (n < LAT + 3);
         if (n > 1) begin
            #1; model_eval();
            n_tests++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL all3_ready_edge%0d: got %b want %b", n, req_ready, m_ready); end
            cycle();
         end
         n_tests++; if (wb_valid !== exp_v) begin n_fail++; $display("FAIL all3_valid_edge%0d: got %0b want %0b", n, wb_valid, exp_v); end
         if (exp_v) begin
            n_tests++; if (wb_src !== wb_src_t'(n - LAT) || wb_rob_id !== 5'(10 + n - LAT)) begin
               n_fail++; $display("FAIL all3_order_edge%0d: got src %0d rob %0d want src %0d rob %0d", n, wb_src, wb_rob_id, n - LAT, 10 + n - LAT);
            end
         end
      end
   endtask

   task automatic test_mul_backpressure();
      int got_rob[$];
      logic [WS-1:0] got_res[$];
      int want_rob[4] = '{1, 2, 4, 5};
      do_reset();
      set_req(REQ_ALU, 4'h1, 32'h10, 32'h1111_0001, 5'd1);
      set_req(REQ_MUL, 4'h2, 32'h30, 32'hAAAA_0002, 5'd2);
      req_valid = 3'b101;
      cycle();
      if (wb_valid) begin got_rob.push_back(int'(wb_rob_id)); got_res.push_back(wb_result); end
      set_req(REQ_ALU, 4'h1, 32'h14, 32'h1111_0004, 5'd4);
      set_req(REQ_MUL, 4'h2, 32'h34, 32'hBBBB_0005, 5'd5);
      req_valid = 3'b101;
      #1;
      n_tests++; if (req_ready[REQ_MUL] !== BYP) begin n_fail++; $display("FAIL mul_ready_full: got %0b want %0b", req_ready[REQ_MUL], BYP); end
      cycle();
      if (wb_valid) begin got_rob.push_back(int'(wb_rob_id)); got_res.push_back(wb_result); end
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < N; i++) if (m_acc[i]) req_valid[i] = 1'b0;
         cycle();
         if (wb_valid) begin got_rob.push_back(int'(wb_rob_id)); got_res.push_back(wb_result); end
      end
      n_tests++; if (got_rob.size() != 4) begin n_fail++; $display("FAIL mul_wb_count: got %0d want 4", got_rob.size()); end
      for (int k = 0; k < 4 && k < got_rob.size(); k++) begin
         n_tests++; if (got_rob[k] != want_rob[k]) begin n_fail++; $display("FAIL mul_wb_order%0d: got rob %0d want %0d", k, got_rob[k], want_rob[k]); end
      end
      if (got_res.size() >= 2) begin
         n_tests++; if (got_res[1] !== 32'hAAAA_0002) begin n_fail++; $display("FAIL mul_held_payload: got %0h want aaaa0002", got_res[1]); end
      end
   endtask

   task automatic test_mem_stream();
      do_reset();
      for (int c = 0; c < 8 + LAT; c++) begin
         automatic int n = c + 1;
         automatic bit exp_v = (n >= LAT) && (n - LAT < 8);
         if (c < 8) begin
            set_req(REQ_MEM, 4'h5, 32'h200 + 32'(c), 32'h7700_0000 + 32'(c), 5'(c));
            req_valid = 3'b010;
         end else begin
            req_valid = '0;
         end
         #1;
         if (c < 8) begin
            n_tests++; if (req_ready[REQ_MEM] !== 1'b1) begin n_fail++; $display("FAIL stream_ready_c%0d: got %0b want 1", c, req_ready[REQ_MEM]); end
         end
         cycle();
         n_tests++; if (wb_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid_edge%0d: got %0b want %0b", n, wb_valid, exp_v); end
         if (exp_v) begin
            n_tests++; if (wb_rob_id !== 5'(n - LAT) || wb_src !== 2'd1) begin
               n_fail++; $display("FAIL stream_rob_edge%0d: got rob %0d src %0d want rob %0d src 1", n, wb_rob_id, wb_src, n - LAT);
            end
         end
      end
   endtask

   task automatic test_flush();
      bit seen = 1'b0;
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 4'h6, 32'h300 + 32'(i), 32'h6600_0000 + 32'(i), 5'(11 + i));
      req_valid = 3'b111;
      cycle();
      req_valid = '0;
      if (LAT == 2) cycle();
      n_tests++; if (wb_valid !== 1'b1 || wb_rob_id !== 5'd11) begin n_fail++; $display("FAIL flush_pre_wb: got valid %0b rob %0d want 1 rob 11", wb_valid, wb_rob_id); end
      for (int i = 0; i < N; i++) set_req(i, 4'h7, 32'h400 + 32'(i), 32'h6700_0000 + 32'(i), 5'(21 + i));
      req_valid = 3'b111;
      flush = 1'b1;
      #1;
      n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready: got %b want 000", req_ready); end
      cycle();
      flush = 1'b0; req_valid = '0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) cycle();
         n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_c%0d: got valid 1 rob %0d want no writeback", c, wb_rob_id); end
      end
      set_req(REQ_ALU, 4'h8, 32'h500, 32'h6800_0000, 5'd24);
      set_req(REQ_MEM, 4'h8, 32'h504, 32'h6800_0001, 5'd25);
      req_valid = 3'b011;
      for (int w = 0; w < 4 && !seen; w++) begin
         cycle();
         req_valid = '0;
         seen = wb_valid;
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL flush_resume_timeout: got no writeback in 4 cycles want one"); end
      if (seen) begin
         n_tests++; if (wb_src !== 2'd1 || wb_rob_id !== 5'd25) begin n_fail++; $display("FAIL flush_ptr_kept: got src %0d rob %0d want src 1 rob 25", wb_src, wb_rob_id); end
         cycle();
         n_tests++; if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_rob_id !== 5'd24) begin
            n_fail++; $display("FAIL flush_second: got valid %0b src %0d rob %0d want 1 src 0 rob 24", wb_valid, wb_src, wb_rob_id);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 4'h9, 32'h600 + 32'(i), 32'h9900_0000 + 32'(i), 5'(1 + i));
      req_valid = 3'b111;
      cycle();
      req_valid = '0;
      cycle();
      n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %0b want 1", wb_valid); end
      #2 reset = 1'b0;
      #1;
      n_tests++; if (wb_valid !== 1'b0 || wb_src !== 2'd0) begin n_fail++; $display("FAIL areset_valid_src: got %0b/%0d want 0/0", wb_valid, wb_src); end
      n_tests++; if ({wb_type, wb_pc, wb_result, wb_rob_id} !== '0) begin n_fail++; $display("FAIL areset_payload: got %0h want 0", {wb_type, wb_pc, wb_result, wb_rob_id}); end
      n_tests++; if (req_ready !== 3'b111) begin n_fail++; $display("FAIL areset_ready: got %b want 111", req_ready); end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         cycle();
         n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL areset_lost_c%0d: got valid 1 rob %0d want 0", c, wb_rob_id); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !m_acc[i])) begin
               req_valid[i] = ($urandom_range(0, 99) < 55);
               set_req(i, IT'($urandom), $urandom, $urandom, RW'($urandom));
            end
         end
         flush = ($urandom_range(0, 31) == 0);
         #1;
         model_eval();
         n_tests++; if (req_ready !== m_ready) begin n_fail++; $display("FAIL rand_ready_c%0d: got %b want %b", c, req_ready, m_ready); end
         cycle();
         n_tests++;
         if ({wb_valid, wb_src, wb_type, wb_pc, wb_result, wb_rob_id} !==
             {m_wbv, wb_src_t'(m_src), m_wtype, m_wpc, m_wres, m_wrob}) begin
            n_fail++;
            $display("FAIL rand_wb_c%0d: got v%0b s%0d t%0h pc%0h r%0h rob%0d want v%0b s%0d t%0h pc%0h r%0h rob%0d",
                     c, wb_valid, wb_src, wb_type, wb_pc, wb_result, wb_rob_id,
                     m_wbv, m_src, m_wtype, m_wpc, m_wres, m_wrob);
         end
      end
      flush = 1'b0; req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_all_three();
      test_mul_backpressure();
      test_mem_stream();
      test_flush();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
